// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane constants and types for the 1-to-16 stream demux
package demux_pkg;

    localparam int SEL_W = 4;
    localparam int LANES = 2 ** SEL_W;

    typedef logic [0:SEL_W-1] lane_t;
    typedef logic [0:LANES-1] lane_vec_t;

endpackage

// File: rtl/demux16_stream_if.sv
// rtl/demux16_stream_if.sv - producer/consumer handshake bundle for demux16_stream
import demux_pkg::*;

interface demux16_stream_if #(
    parameter int DATA_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [0:DATA_W-1] in_data;
    lane_t             in_sel;
    lane_vec_t         out_valid;
    lane_vec_t         out_ready;
    logic [0:DATA_W-1] out_data;
    logic              busy;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/dec4to16_gate.sv
// rtl/dec4to16_gate.sv - enabled one-hot 4-to-16 decoder built from two 2-to-4 levels
import demux_pkg::*;

module dec4to16_gate (
    input  logic      en,
    input  lane_t     sel,
    output lane_vec_t dec
);

    logic [0:3] hi;

    // s[0] is the more significant select bit
    function automatic logic [0:3] dec2to4(input logic e, input logic [0:1] s);
        logic [0:3] r;
        r[0] = e & ~s[0] & ~s[1];
        r[1] = e & ~s[0] &  s[1];
        r[2] = e &  s[0] & ~s[1];
        r[3] = e &  s[0] &  s[1];
        return r;
    endfunction

    assign hi = dec2to4(en, sel[0:1]);

    for (genvar g = 0; g < 4; g++) begin : g_lo
        assign dec[4*g +: 4] = dec2to4(hi[g], sel[2:3]);
    end

endmodule

// File: rtl/demux16_stream.sv
// rtl/demux16_stream.sv - registered 1-to-16 valid/ready stream demux, one holding stage
// Optional round-robin destination selection under DEMUX16_AUTOSEL_EN.
module demux16_stream #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef DEMUX16_AUTOSEL_EN
    input  logic auto_mode,
`endif
    demux16_stream_if.slave s
);

    logic [0:DATA_W-1] data_q;
    logic [0:SEL_W-1]  lane_q;
    logic              full_q;
    logic [0:SEL_W-1]  dest;
    logic              pop;
    logic              push;

    // Only the occupied lane's ready matters; in_ready passes it through for full throughput
    assign pop        = full_q & s.out_ready[lane_q];
    assign s.in_ready = ~full_q | pop;
    assign push       = s.in_valid & s.in_ready;

`ifdef DEMUX16_AUTOSEL_EN
    logic [0:SEL_W-1] rr_q;

    assign dest = auto_mode ? rr_q : s.in_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else if (push && auto_mode) begin
            rr_q <= rr_q + 1'b1;
        end
    end
`else
    assign dest = s.in_sel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            lane_q <= '0;
            data_q <= '0;
        end else if (push) begin
            full_q <= 1'b1;
            lane_q <= dest;
            data_q <= s.in_data;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    dec4to16_gate u_dec (
        .en  (full_q),
        .sel (lane_q),
        .dec (s.out_valid)
    );

    assign s.out_data = data_q;
    assign s.busy     = full_q;

endmodule

// File: tb/tb_demux16_stream.sv
// tb/tb_demux16_stream.sv - directed self-checking bench for demux16_stream
module tb_demux16_stream;

    logic clk;
    logic rst;
`ifdef DEMUX16_AUTOSEL_EN
    logic auto_mode;
`endif

    int n_cmp;
    int n_fail;

    demux16_stream_if #(.DATA_W(8)) bus ();

    demux16_stream #(.DATA_W(8), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DEMUX16_AUTOSEL_EN
        .auto_mode (auto_mode),
`endif
        .s         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:15] onehot(input int i);
        logic [0:15] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:15] all_but(input int i);
        logic [0:15] v;
        v    = '1;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer must hold data/sel while offered and not accepted
    logic       pend;
    logic [0:7] pend_data;
    logic [0:3] pend_sel;
    initial pend = 1'b0;

    always @(posedge clk) begin
        if (pend) begin
            n_cmp++;
            if (bus.in_data !== pend_data || bus.in_sel !== pend_sel) begin
                n_fail++;
                $display("FAIL producer_hold: data=%h sel=%h required data=%h sel=%h",
                         bus.in_data, bus.in_sel, pend_data, pend_sel);
            end
        end
        pend      <= bus.in_valid && !bus.in_ready && !rst;
        pend_data <= bus.in_data;
        pend_sel  <= bus.in_sel;
    end

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'hFF;
        bus.in_sel    = 4'hF;
        bus.out_ready = '1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b required %b", bus.out_valid, 16'h0000);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 0", bus.busy);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h required 00", bus.out_data);
        end
    endtask

    task automatic test_sweep();
        bus.out_ready = '1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 4'(i);
            bus.in_data  = 8'hA0 + 8'(i);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_in_ready[%0d]: got %b required 1", i, bus.in_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== onehot(i) || bus.out_data !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL sweep_lane[%0d]: got valid=%b data=%h required valid=%b data=%h",
                         i, bus.out_valid, bus.out_data, onehot(i), 8'hA0 + 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.out_valid !== 16'h0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_drain: got valid=%b busy=%b required 0 / 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_stall();
        bus.out_ready = all_but(5);
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd5;
        bus.in_data   = 8'h5A;
        tick();
        bus.in_sel  = 4'd2;
        bus.in_data = 8'h77;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== onehot(5) || bus.out_data !== 8'h5A) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got ready=%b valid=%b data=%h required 0 / %b / 5a",
                         k, bus.in_ready, bus.out_valid, bus.out_data, onehot(5));
            end
            tick();
        end
        bus.out_ready = '1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: got %b required 1", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== onehot(2) || bus.out_data !== 8'h77) begin
            n_fail++;
            $display("FAIL stall_pending_word: got valid=%b data=%h required %b / 77",
                     bus.out_valid, bus.out_data, onehot(2));
        end
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.out_valid !== 16'h0000) begin
            n_fail++;
            $display("FAIL stall_drain: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = '1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd3;
        bus.in_data   = 8'h11;
        tick();
        n_cmp++;
        if (bus.out_valid !== onehot(3) || bus.out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b data=%h required %b / 11",
                     bus.out_valid, bus.out_data, onehot(3));
        end
        bus.in_sel  = 4'd12;
        bus.in_data = 8'h22;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b required 1", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== onehot(12) || bus.out_data !== 8'h22) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%b data=%h required %b / 22",
                     bus.out_valid, bus.out_data, onehot(12));
        end
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.out_valid !== 16'h0000) begin
            n_fail++;
            $display("FAIL b2b_drain: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = all_but(9);
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd9;
        bus.in_data   = 8'hC3;
        tick();
        n_cmp++;
        if (bus.out_valid !== onehot(9) || bus.out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL rstmid_held: got valid=%b data=%h required %b / c3",
                     bus.out_valid, bus.out_data, onehot(9));
        end
        bus.in_sel  = 4'd1;
        bus.in_data = 8'h3C;
        rst         = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 16'h0000 || bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_cleared: got valid=%b busy=%b data=%h required 0 / 0 / 00",
                     bus.out_valid, bus.busy, bus.out_data);
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = '1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 16'h0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_not_delivered: got valid=%b busy=%b required 0 / 0",
                     bus.out_valid, bus.busy);
        end
    endtask

`ifdef DEMUX16_AUTOSEL_EN
    task automatic test_auto();
        bus.out_ready = '1;
        auto_mode     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd0;
        for (int i = 0; i < 18; i++) begin
            bus.in_data = 8'h40 + 8'(i);
            tick();
            n_cmp++;
            if (bus.out_valid !== onehot(i % 16) || bus.out_data !== 8'h40 + 8'(i)) begin
                n_fail++;
                $display("FAIL auto_lane[%0d]: got valid=%b data=%h required %b / %h",
                         i, bus.out_valid, bus.out_data, onehot(i % 16), 8'h40 + 8'(i));
            end
        end
        auto_mode   = 1'b0;
        bus.in_sel  = 4'd7;
        bus.in_data = 8'h99;
        tick();
        n_cmp++;
        if (bus.out_valid !== onehot(7) || bus.out_data !== 8'h99) begin
            n_fail++;
            $display("FAIL auto_off_sel: got valid=%b data=%h required %b / 99",
                     bus.out_valid, bus.out_data, onehot(7));
        end
        auto_mode   = 1'b1;
        bus.in_data = 8'h5C;
        tick();
        n_cmp++;
        if (bus.out_valid !== onehot(2)) begin
            n_fail++;
            $display("FAIL auto_rr_held: got %b required %b", bus.out_valid, onehot(2));
        end
        bus.in_valid = 1'b0;
        auto_mode    = 1'b0;
        tick();
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
`ifdef DEMUX16_AUTOSEL_EN
        auto_mode = 1'b0;
`endif
        test_reset();
        test_sweep();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef DEMUX16_AUTOSEL_EN
        test_auto();
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
